// File: rtl/negate_arbiter.sv
// negate_arbiter: round-robin arbiter sharing one negation unit between NREQ
// valid/ready requesters, with a single-entry output register toward one consumer.
module negate_arbiter #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8,
   parameter int MODE  = 0
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [NREQ-1:0]           req_valid,
   input  logic [NREQ*WIDTH-1:0]     req_data,
   output logic [NREQ-1:0]           req_ready,
   output logic                      out_valid,
   output logic [WIDTH-1:0]          out_data,
   output logic [$clog2(NREQ)-1:0]   out_id,
   input  logic                      out_ready,
   output logic [15:0]               done_count
);
   localparam int IW = $clog2(NREQ);
   localparam logic [0:0] EMPTY = 1'b0;
   localparam logic [0:0] FULL  = 1'b1;

   logic [0:0]       state;
   logic [IW-1:0]    ptr;
   logic [IW-1:0]    win;
   logic [IW-1:0]    idx;
   logic             found;
   logic             can_accept;
   logic             accept;
   logic             consume;
   logic [WIDTH-1:0] win_data;
   logic [WIDTH-1:0] neg_data;
   int               p;

   // Rotating priority search: first valid requester at or after ptr wins.
   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = '0;
      p     = 0;
      for (int k = 0; k < NREQ; k++) begin
         p = int'(ptr) + k;
         if (p >= NREQ) p = p - NREQ;
         idx = IW'(p);
         if (!found && req_valid[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   assign out_valid  = (state == FULL);
   assign can_accept = !reset && (!out_valid || out_ready);
   assign req_ready  = (found && can_accept) ? (NREQ'(1) << win) : '0;
   assign accept     = found && can_accept;
   assign consume    = out_valid && out_ready;
   assign win_data   = req_data[win*WIDTH +: WIDTH];
   assign neg_data   = (MODE == 1) ? -win_data : ~win_data;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= EMPTY;
         ptr        <= '0;
         out_data   <= '0;
         out_id     <= '0;
         done_count <= '0;
      end else begin
         if (accept) begin
            state    <= FULL;
            out_data <= neg_data;
            out_id   <= win;
            ptr      <= (win == IW'(NREQ - 1)) ? '0 : win + IW'(1);
         end else if (consume) begin
            state <= EMPTY;
         end
         if (consume) done_count <= done_count + 16'd1;
      end
   end
endmodule

// File: tb/tb_negate_arbiter.sv
// tb_negate_arbiter: directed stimulus into a 4-requester invert instance and a
// 3-requester two's-complement instance, checked against a behavioural model.
module tb_negate_arbiter;
   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [3:0]  rv = '0;
   logic [31:0] rd = '0;
   logic        ordy = 1'b0;

   logic [3:0]  rr0;
   logic        ov0;
   logic [7:0]  od0;
   logic [1:0]  oi0;
   logic [15:0] dc0;
   logic [2:0]  rr1;
   logic        ov1;
   logic [7:0]  od1;
   logic [1:0]  oi1;
   logic [15:0] dc1;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   negate_arbiter #(.NREQ(4), .WIDTH(8), .MODE(0)) u0 (
      .clock(clock), .reset(reset), .req_valid(rv), .req_data(rd),
      .req_ready(rr0), .out_valid(ov0), .out_data(od0), .out_id(oi0),
      .out_ready(ordy), .done_count(dc0));

   negate_arbiter #(.NREQ(3), .WIDTH(8), .MODE(1)) u1 (
      .clock(clock), .reset(reset), .req_valid(rv[2:0]), .req_data(rd[23:0]),
      .req_ready(rr1), .out_valid(ov1), .out_data(od1), .out_id(oi1),
      .out_ready(ordy), .done_count(dc1));

   // Model: instance 0 has 4 requesters and inverts, instance 1 has 3 and negates.
   logic        mv[2];
   logic [7:0]  md[2];
   int          mid[2];
   int          mptr[2];
   logic [15:0] mdc[2];

   function automatic int nr(int i);
      return (i == 0) ? 4 : 3;
   endfunction

   function automatic int grant(int i, int start);
      for (int k = 0; k < nr(i); k++) begin
         int j = (start + k) % nr(i);
         if (rv[j]) return j;
      end
      return -1;
   endfunction

   function automatic logic [7:0] neg(int i, logic [7:0] x);
      return (i == 0) ? 8'hFF - x : 8'(9'h100 - {1'b0, x});
   endfunction

   function automatic logic [3:0] exp_rr(int i);
      int g = grant(i, mptr[i]);
      if (g < 0 || reset || (mv[i] && !ordy)) return 4'b0;
      return 4'(1 << g);
   endfunction

   always @(posedge clock or posedge reset) begin
      for (int i = 0; i < 2; i++) begin
         if (reset) begin
            mv[i] <= 1'b0; md[i] <= '0; mid[i] <= 0; mptr[i] <= 0; mdc[i] <= '0;
         end else begin
            if (mv[i] && ordy) mdc[i] <= mdc[i] + 16'd1;
            if (exp_rr(i) != 4'b0) begin
               md[i]   <= neg(i, rd[grant(i, mptr[i])*8 +: 8]);
               mid[i]  <= grant(i, mptr[i]);
               mv[i]   <= 1'b1;
               mptr[i] <= (grant(i, mptr[i]) + 1) % nr(i);
            end else if (mv[i] && ordy) begin
               mv[i] <= 1'b0;
            end
         end
      end
   end

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", n, a, e, $time);
      end
   endtask

   always @(negedge clock) begin
      #2;
      chk("u0 req_ready", 32'(rr0), 32'(exp_rr(0)));
      chk("u0 out_valid", 32'(ov0), 32'(mv[0]));
      chk("u0 done_count", 32'(dc0), 32'(mdc[0]));
      chk("u1 req_ready", 32'(rr1), 32'(exp_rr(1)));
      chk("u1 out_valid", 32'(ov1), 32'(mv[1]));
      chk("u1 done_count", 32'(dc1), 32'(mdc[1]));
      if (mv[0]) begin
         chk("u0 out_data", 32'(od0), 32'(md[0]));
         chk("u0 out_id", 32'(oi0), mid[0]);
      end
      if (mv[1]) begin
         chk("u1 out_data", 32'(od1), 32'(md[1]));
         chk("u1 out_id", 32'(oi1), mid[1]);
      end
   end

   logic [7:0] vin[4]  = '{8'h01, 8'h00, 8'h80, 8'h7F};
   logic [7:0] vexp[4] = '{8'hFF, 8'h00, 8'h80, 8'h81};

   initial begin
      #1 reset = 1'b1;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clock); #3;
         chk("idle out_valid", 32'(ov0), 0);
         chk("idle req_ready", 32'(rr0), 0);
         chk("idle done_count", 32'(dc0), 0);
         chk("idle out_data", 32'(od0), 0);
      end
      // single request from requester 2
      @(negedge clock);
      rv = 4'b0100; rd = 32'h00A50000; ordy = 1'b1;
      #3 chk("t2 req_ready", 32'(rr0), 32'b0100);
      @(negedge clock);
      rv = 4'b0000;
      #3;
      chk("t2 out_valid", 32'(ov0), 1);
      chk("t2 out_data", 32'(od0), 32'h5A);
      chk("t2 out_id", 32'(oi0), 2);
      chk("t2 u1 out_data", 32'(od1), 32'h5B);
      @(negedge clock); #3;
      chk("t2 done_count", 32'(dc0), 1);
      chk("t2 drained", 32'(ov0), 0);
      @(negedge clock); reset = 1'b1;
      @(negedge clock); reset = 1'b0;
      // all requesters valid, no backpressure
      rv = 4'hF; rd = 32'h44332211; ordy = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clock); #3;
         chk("t3 out_id", 32'(oi0), k % 4);
         chk("t3 u1 out_id", 32'(oi1), k % 3);
         chk("t3 done_count", 32'(dc0), k);
      end
      // backpressure
      @(negedge clock); rv = 4'b0000;
      @(negedge clock); rv = 4'b0010; rd = 32'h00003C00; ordy = 1'b0;
      #3 chk("t4 accept", 32'(rr0), 32'b0010);
      @(negedge clock); rv = 4'b1000; rd = 32'h11000000;
      for (int k = 0; k < 6; k++) begin
         #3;
         chk("t4 stall req_ready", 32'(rr0), 0);
         chk("t4 stall out_data", 32'(od0), 32'hC3);
         chk("t4 stall out_id", 32'(oi0), 1);
         @(negedge clock);
      end
      ordy = 1'b1;
      #3 chk("t4 release req_ready", 32'(rr0), 32'b1000);
      @(negedge clock); #3;
      chk("t4 next out_data", 32'(od0), 32'hEE);
      chk("t4 next out_id", 32'(oi0), 3);
      // two's-complement corner values on the MODE=1 instance
      rv = 4'b0001;
      for (int k = 0; k < 4; k++) begin
         @(negedge clock);
         rd = {24'h0, vin[k]};
         #3 if (k > 0) chk("t5 u1 out_data", 32'(od1), 32'(vexp[k-1]));
      end
      @(negedge clock);
      rv = 4'b0000;
      #3 chk("t5 u1 out_data", 32'(od1), 32'(vexp[3]));
      // reset while full
      @(negedge clock); rv = 4'b0100; rd = 32'h00770000; ordy = 1'b0;
      @(negedge clock); rv = 4'b0000;
      #3 chk("t6 full", 32'(ov0), 1);
      #1 reset = 1'b1;
      #1;
      chk("t6 async out_valid", 32'(ov0), 0);
      chk("t6 async u1 out_valid", 32'(ov1), 0);
      chk("t6 req_ready in reset", 32'(rr0), 0);
      @(negedge clock);
      reset = 1'b0; rv = 4'b1001; rd = 32'h55000066; ordy = 1'b1;
      #3;
      chk("t6 ptr reset grant", 32'(rr0), 32'b0001);
      chk("t6 u1 ptr reset grant", 32'(rr1), 32'b001);
      @(negedge clock); #3;
      chk("t6 out_id", 32'(oi0), 0);
      chk("t6 out_data", 32'(od0), 32'h99);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
